// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, idle/column codes, defaults.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StPressed,
    StRelease
  } kp_state_e;

  localparam logic [3:0] KP_IDLE = 4'hF;
  localparam logic [3:0] KP_COL0 = 4'b1110;

  localparam int unsigned COL_CYCLES_DEF = 1000;
  localparam int unsigned DEB_CYCLES_DEF = 50000;

  // More than one active-low row means several keys are down at once.
  function automatic logic multi_zero(input logic [3:0] v);
    return ($countones(~v) > 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the raw keypad rows; resets to the idle (all-high) pattern.
module sync2
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= KP_IDLE;
      q      <= KP_IDLE;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with press/release debounce and registered outputs.
// Optional multi-key rejection is enabled by defining KEYPAD_SCAN_GHOST_REJECT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned COL_CYCLES = COL_CYCLES_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr_raw,
  output logic [3:0] kpc,
  output logic [3:0] kpr,
  output logic       key_valid,
  output logic       key_press
);

  localparam int unsigned ColW = $clog2(COL_CYCLES);
  localparam int unsigned DebW = $clog2(DEB_CYCLES);
  localparam logic [ColW-1:0] ColLast = ColW'(COL_CYCLES - 1);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

  kp_state_e       state;
  logic [ColW-1:0] col_cnt;
  logic [DebW-1:0] deb_cnt;
  logic [3:0]      cap_r;
  logic [3:0]      ks;
  logic [3:0]      ks_f;
  logic [3:0]      next_col;

  sync2 u_sync2 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (kpr_raw),
    .q       (ks)
  );

`ifdef KEYPAD_SCAN_GHOST_REJECT_EN
  assign ks_f = multi_zero(ks) ? KP_IDLE : ks;
`else
  assign ks_f = ks;
`endif

  assign next_col = {kpc[2:0], kpc[3]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= StScan;
      kpc       <= KP_COL0;
      kpr       <= KP_IDLE;
      key_valid <= 1'b0;
      key_press <= 1'b0;
      col_cnt   <= '0;
      deb_cnt   <= '0;
      cap_r     <= KP_IDLE;
    end else begin
      key_press <= 1'b0;
      unique case (state)
        StScan: begin
          if (col_cnt == ColLast) begin
            col_cnt <= '0;
            // Rows are only looked at once the column has settled through the synchronizer.
            if (ks_f != KP_IDLE) begin
              cap_r   <= ks_f;
              deb_cnt <= '0;
              state   <= StDebounce;
            end else begin
              kpc <= next_col;
            end
          end else begin
            col_cnt <= col_cnt + ColW'(1);
          end
        end

        StDebounce: begin
          if (ks_f != cap_r) begin
            state   <= StScan;
            kpc     <= next_col;
            col_cnt <= '0;
            deb_cnt <= '0;
          end else if (deb_cnt == DebLast) begin
            state     <= StPressed;
            deb_cnt   <= '0;
            kpr       <= cap_r;
            key_valid <= 1'b1;
            key_press <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DebW'(1);
          end
        end

        StPressed: begin
          // Only a full release matters here; a different key pattern is ignored.
          if (ks == KP_IDLE) begin
            state   <= StRelease;
            deb_cnt <= '0;
          end
        end

        StRelease: begin
          if (ks_f != KP_IDLE) begin
            state   <= StPressed;
            deb_cnt <= '0;
          end else if (deb_cnt == DebLast) begin
            state     <= StScan;
            kpc       <= next_col;
            col_cnt   <= '0;
            deb_cnt   <= '0;
            kpr       <= KP_IDLE;
            key_valid <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + DebW'(1);
          end
        end

        default: state <= StScan;
      endcase
    end
  end

endmodule
